// File: rtl/axis_pixel_source.sv
// Reads one frame of pixels from a synchronous-read memory and streams it out over AXI-Stream.
// A 2-entry skid FIFO absorbs the one-cycle read latency so a continuously ready sink gets one beat per cycle.
module axis_pixel_source #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 21,
    parameter int FRAME_LEN = 1049600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] axi_data_out,
    output logic              axi_valid_out,
    output logic              axi_keep_out,
    output logic              axi_last_out,
    input  logic              axi_ready_in,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] C_LEN  = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [ADDR_W:0] C_LAST = (ADDR_W+1)'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_beat_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_level;
    logic              w_frame_end;
    logic              w_start_frame;

    assign axi_valid_out = (r_count != 2'd0);
    assign axi_keep_out  = axi_valid_out;
    assign axi_data_out  = r_fifo_data[r_rd_ptr];
    assign axi_last_out  = axi_valid_out & r_fifo_last[r_rd_ptr];
    assign done          = r_done;

    assign w_pop         = axi_valid_out & axi_ready_in;
    assign w_push        = r_inflight;
    // Entries that will be occupied next cycle if no new read is issued now.
    assign w_level       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_frame_end   = w_pop & (r_beat_cnt == C_LAST);
    assign w_start_frame = (r_state == S_IDLE) & start;

    assign mem_addr      = mem_rd_en ? r_rd_cnt[ADDR_W-1:0] : r_mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_rd_en    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                mem_rd_en = (r_rd_cnt < C_LEN) && (w_level <= 3'd1);
                if (w_frame_end) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt        <= '0;
            r_beat_cnt      <= '0;
            r_mem_addr      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= 2'b00;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            r_done     <= w_frame_end;
            r_inflight <= mem_rd_en;

            if (w_start_frame) begin
                r_rd_cnt   <= '0;
                r_beat_cnt <= '0;
            end else begin
                if (mem_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (w_pop) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end

            if (mem_rd_en) begin
                r_mem_addr      <= r_rd_cnt[ADDR_W-1:0];
                r_inflight_last <= (r_rd_cnt == C_LAST);
            end

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= mem_rd_data;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pixel_source.sv
// Directed bench for axis_pixel_source: FRAME_LEN=4 main instance plus a FRAME_LEN=1 instance,
// memory model returns 8'h10 + address one cycle after each read strobe.
module tb_axis_pixel_source;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          start = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] axi_data_out;
    logic          axi_valid_out;
    logic          axi_keep_out;
    logic          axi_last_out;
    logic          ready = 1'b0;
    logic          busy;
    logic          done;

    logic          start_1 = 1'b0;
    logic          mem_rd_en_1;
    logic [AW-1:0] mem_addr_1;
    logic [DW-1:0] mem_rd_data_1 = '0;
    logic [DW-1:0] axi_data_out_1;
    logic          axi_valid_out_1;
    logic          axi_keep_out_1;
    logic          axi_last_out_1;
    logic          ready_1 = 1'b1;
    logic          busy_1;
    logic          done_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_pixel_source #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .axi_data_out (axi_data_out),
        .axi_valid_out(axi_valid_out),
        .axi_keep_out (axi_keep_out),
        .axi_last_out (axi_last_out),
        .axi_ready_in (ready),
        .busy         (busy),
        .done         (done)
    );

    axis_pixel_source #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_1),
        .mem_rd_en    (mem_rd_en_1),
        .mem_addr     (mem_addr_1),
        .mem_rd_data  (mem_rd_data_1),
        .axi_data_out (axi_data_out_1),
        .axi_valid_out(axi_valid_out_1),
        .axi_keep_out (axi_keep_out_1),
        .axi_last_out (axi_last_out_1),
        .axi_ready_in (ready_1),
        .busy         (busy_1),
        .done         (done_1)
    );

    always @(posedge clk) begin
        if (mem_rd_en)   mem_rd_data   <= 8'h10 + 8'(mem_addr);
        if (mem_rd_en_1) mem_rd_data_1 <= 8'h10 + 8'(mem_addr_1);
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; start_1 = 1'b1; ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({mem_rd_en, mem_addr} !== '0) begin
            bad++; $display("FAIL reset_mem: got rd=%b addr=%0h expected 0/0", mem_rd_en, mem_addr);
        end
        total++;
        if ({axi_valid_out, axi_keep_out, axi_last_out} !== 3'b000) begin
            bad++; $display("FAIL reset_axi: got v/k/l=%b%b%b expected 000", axi_valid_out, axi_keep_out, axi_last_out);
        end
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done);
        end
        total++;
        if ({mem_rd_en_1, axi_valid_out_1, busy_1, done_1} !== 4'b0000) begin
            bad++; $display("FAIL reset_dut1: got %b%b%b%b expected 0000", mem_rd_en_1, axi_valid_out_1, busy_1, done_1);
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; start_1 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if ({busy, axi_valid_out, mem_rd_en} !== 3'b000) begin
            bad++; $display("FAIL reset_start_not_latched: got busy/valid/rd=%b%b%b expected 000", busy, axi_valid_out, mem_rd_en);
        end
    endtask

    task automatic test_basic();
        int n = 0; int first_valid = -1; int done_c = -1; logic done_seen = 1'b0;
        logic [7:0] exp_d;
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        total++;
        if ({mem_rd_en, mem_addr, busy, axi_valid_out} !== {1'b1, 4'h0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL basic_first_read: got rd=%b addr=%0h busy=%b valid=%b expected 1 0 1 0", mem_rd_en, mem_addr, busy, axi_valid_out);
        end
        for (int c = 1; c <= 12 && !done_seen; c++) begin
            @(negedge clk); #1;
            if (done) begin
                done_seen = 1'b1; done_c = c;
            end else if (axi_valid_out) begin
                if (first_valid < 0) first_valid = c;
                exp_d = 8'h10 + 8'(n);
                total++;
                if ({axi_data_out, axi_last_out, axi_keep_out} !== {exp_d, (n == 3), 1'b1}) begin
                    bad++; $display("FAIL basic_beat%0d: got data=%0h last=%b keep=%b expected %0h %b 1", n, axi_data_out, axi_last_out, axi_keep_out, exp_d, (n == 3));
                end
                n++;
            end
        end
        total++;
        if (first_valid != 2 || n != 4 || done_c != 6) begin
            bad++; $display("FAIL basic_timing: got first_valid=%0d beats=%0d done_at=%0d expected 2 4 6", first_valid, n, done_c);
        end
        total++;
        if ({busy, axi_valid_out, mem_rd_en} !== 3'b000) begin
            bad++; $display("FAIL basic_done_idle: got busy/valid/rd=%b%b%b expected 000", busy, axi_valid_out, mem_rd_en);
        end
        @(negedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse: got done=%b expected 0", done);
        end
    endtask

    task automatic test_toggle();
        logic [19:0] pat = 20'b1111_1110_1011_0010_1001;
        int occ = 0; int infl = 0; int issued = 0; int n = 0;
        logic exp_rd; logic exp_v; logic xfer; logic done_seen = 1'b0;
        logic prev_hold = 1'b0; logic [7:0] prev_d = '0; logic prev_l = 1'b0;
        logic [7:0] exp_d;
        ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            ready = (i < 20) ? pat[i] : 1'b1;
            #1;
            if (done) begin
                done_seen = 1'b1;
            end else begin
                exp_v  = (occ > 0);
                xfer   = exp_v && ready;
                exp_rd = (issued < 4) && ((occ + infl - (xfer ? 1 : 0)) <= 1);
                total++;
                if (axi_valid_out !== exp_v || mem_rd_en !== exp_rd) begin
                    bad++; $display("FAIL toggle_ctl i=%0d: got valid=%b rd=%b expected %b %b", i, axi_valid_out, mem_rd_en, exp_v, exp_rd);
                end
                if (exp_rd) begin
                    total++;
                    if (mem_addr !== 4'(issued)) begin
                        bad++; $display("FAIL toggle_addr: got %0h expected %0h", mem_addr, 4'(issued));
                    end
                end
                if (prev_hold) begin
                    total++;
                    if ({axi_data_out, axi_last_out} !== {prev_d, prev_l}) begin
                        bad++; $display("FAIL toggle_stable: got %0h/%b expected %0h/%b", axi_data_out, axi_last_out, prev_d, prev_l);
                    end
                end
                if (xfer) begin
                    exp_d = 8'h10 + 8'(n);
                    total++;
                    if ({axi_data_out, axi_last_out} !== {exp_d, (n == 3)}) begin
                        bad++; $display("FAIL toggle_beat%0d: got %0h/%b expected %0h/%b", n, axi_data_out, axi_last_out, exp_d, (n == 3));
                    end
                    n++;
                end
                prev_hold = exp_v && !ready;
                prev_d    = axi_data_out;
                prev_l    = axi_last_out;
                occ       = occ + infl - (xfer ? 1 : 0);
                infl      = exp_rd ? 1 : 0;
                issued    = issued + (exp_rd ? 1 : 0);
                @(negedge clk);
            end
        end
        total++;
        if (!done_seen || n != 4) begin
            bad++; $display("FAIL toggle_end: got done_seen=%b beats=%0d expected 1 4", done_seen, n);
        end
    endtask

    task automatic test_stall();
        int reads = 0; int n = 0; logic done_seen = 1'b0;
        logic [7:0] exp_d;
        ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_rd_en) reads++;
            @(negedge clk);
        end
        #1;
        total++;
        if (reads != 2 || {axi_valid_out, axi_data_out, axi_last_out} !== {1'b1, 8'h10, 1'b0}) begin
            bad++; $display("FAIL stall_hold: got reads=%0d valid=%b data=%0h last=%b expected 2 1 10 0", reads, axi_valid_out, axi_data_out, axi_last_out);
        end
        ready = 1'b1;
        for (int c = 0; c < 12 && !done_seen; c++) begin
            #1;
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (axi_valid_out) begin
                    exp_d = 8'h10 + 8'(n);
                    total++;
                    if ({axi_data_out, axi_last_out} !== {exp_d, (n == 3)}) begin
                        bad++; $display("FAIL stall_beat%0d: got %0h/%b expected %0h/%b", n, axi_data_out, axi_last_out, exp_d, (n == 3));
                    end
                    n++;
                end
                @(negedge clk);
            end
        end
        total++;
        if (!done_seen || n != 4) begin
            bad++; $display("FAIL stall_end: got done_seen=%b beats=%0d expected 1 4", done_seen, n);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0; int frames = 0; int done_c = -1; int fv2 = -1;
        logic [7:0] exp_d;
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 30 && frames < 2; c++) begin
            @(negedge clk);
            if (done) begin
                frames++;
                if (frames == 1) begin
                    done_c = c;
                    total++;
                    if (n != 4) begin
                        bad++; $display("FAIL b2b_first_frame_beats: got %0d expected 4", n);
                    end
                end
            end
            start = (c == 3) || (c == 4) || (done && frames == 1);
            #1;
            if (axi_valid_out) begin
                if (n == 4 && fv2 < 0) fv2 = c;
                exp_d = 8'h10 + 8'(n % 4);
                total++;
                if ({axi_data_out, axi_last_out} !== {exp_d, ((n % 4) == 3)}) begin
                    bad++; $display("FAIL b2b_beat%0d: got %0h/%b expected %0h/%b", n, axi_data_out, axi_last_out, exp_d, ((n % 4) == 3));
                end
                n++;
            end
        end
        start = 1'b0;
        total++;
        if (frames != 2 || n != 8 || done_c != 6 || fv2 != done_c + 3) begin
            bad++; $display("FAIL b2b_summary: got frames=%0d beats=%0d done_at=%0d second_valid=%0d expected 2 8 6 9", frames, n, done_c, fv2);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({busy, axi_valid_out} !== 2'b00) begin
            bad++; $display("FAIL b2b_no_third: got busy/valid=%b%b expected 00", busy, axi_valid_out);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0; logic done_seen = 1'b0; int leak = 0;
        logic [7:0] exp_d;
        ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 10 && n < 2; c++) begin
            @(negedge clk); #1;
            if (axi_valid_out) n++;
        end
        @(negedge clk); #1;
        total++;
        if ({axi_valid_out, busy} !== 2'b11) begin
            bad++; $display("FAIL rstmid_pre: got valid/busy=%b%b expected 11", axi_valid_out, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_rd_en, mem_addr, axi_valid_out, axi_keep_out, axi_last_out, busy, done} !== '0) begin
            bad++; $display("FAIL rstmid_immediate: got rd=%b addr=%0h v=%b k=%b l=%b busy=%b done=%b expected all 0",
                            mem_rd_en, mem_addr, axi_valid_out, axi_keep_out, axi_last_out, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (axi_valid_out || mem_rd_en || busy) leak++;
        end
        total++;
        if (leak != 0) begin
            bad++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", leak);
        end
        n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 12 && !done_seen; c++) begin
            #1;
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (axi_valid_out) begin
                    exp_d = 8'h10 + 8'(n);
                    total++;
                    if ({axi_data_out, axi_last_out} !== {exp_d, (n == 3)}) begin
                        bad++; $display("FAIL rstmid_beat%0d: got %0h/%b expected %0h/%b", n, axi_data_out, axi_last_out, exp_d, (n == 3));
                    end
                    n++;
                end
                @(negedge clk);
            end
        end
        total++;
        if (!done_seen || n != 4) begin
            bad++; $display("FAIL rstmid_end: got done_seen=%b beats=%0d expected 1 4", done_seen, n);
        end
    endtask

    task automatic test_frame1();
        ready_1 = 1'b1;
        @(negedge clk); start_1 = 1'b1;
        @(negedge clk); start_1 = 1'b0;
        #1;
        total++;
        if ({mem_rd_en_1, mem_addr_1} !== {1'b1, 4'h0}) begin
            bad++; $display("FAIL f1_read: got rd=%b addr=%0h expected 1 0", mem_rd_en_1, mem_addr_1);
        end
        @(negedge clk); #1;
        total++;
        if ({mem_rd_en_1, axi_valid_out_1} !== 2'b00) begin
            bad++; $display("FAIL f1_single_read: got rd/valid=%b%b expected 00", mem_rd_en_1, axi_valid_out_1);
        end
        @(negedge clk); #1;
        total++;
        if ({axi_valid_out_1, axi_data_out_1, axi_last_out_1, axi_keep_out_1} !== {1'b1, 8'h10, 1'b1, 1'b1}) begin
            bad++; $display("FAIL f1_beat: got v=%b data=%0h last=%b keep=%b expected 1 10 1 1", axi_valid_out_1, axi_data_out_1, axi_last_out_1, axi_keep_out_1);
        end
        @(negedge clk); #1;
        total++;
        if ({done_1, busy_1, axi_valid_out_1} !== 3'b100) begin
            bad++; $display("FAIL f1_done: got done/busy/valid=%b%b%b expected 100", done_1, busy_1, axi_valid_out_1);
        end
        @(negedge clk); #1;
        total++;
        if (done_1 !== 1'b0) begin
            bad++; $display("FAIL f1_done_pulse: got done=%b expected 0", done_1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_frame1();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
